fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the microcoded control unit.
//  Owns the PC and the instruction register (IR), and reads instruction words over a req/valid handshake.
//  Drives opcode = ir[15:11] into the control unit's microsequencer.
//  Fetch start, jump and call PC loads come from control-unit signal bits. A watchdog flags memories that never answer.
// PARAMETERS
//  PC_W      11  PC / instruction-memory address width (wraps modulo 2**PC_W)
//  INSTR_W   16  instruction word width; opcode is always ir[INSTR_W-1:INSTR_W-5]
//  MAX_WAIT  15  cycles spent in REQ without mem_valid before timeout fault
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  fetch_req    in   1        start a fetch (control-unit signal); sampled only in IDLE
//  pc_load      in   1        load PC with pc_load_val (jump/call/ret)
//  pc_load_val  in   PC_W     new PC value
//  mem_req      out  1        read request to instruction memory
//  mem_addr     out  PC_W     read address; equals the PC being fetched
//  mem_rdata    in   INSTR_W  instruction word; valid when mem_valid=1
//  mem_valid    in   1        memory response strobe
//  pc           out  PC_W     current PC
//  ir           out  INSTR_W  instruction register
//  opcode       out  5        ir[INSTR_W-1:INSTR_W-5], combinational from ir
//  ir_valid     out  1        one-cycle pulse: ir updated this cycle
//  busy         out  1        1 while state != IDLE
//  fault        out  1        sticky timeout flag; cleared only by rst
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, pc=0, ir=0, mem_req=0, ir_valid=0, fault=0, wait_cnt=0, pend=0.
//    rst mid-fetch abandons the request; a mem_valid arriving later in IDLE is ignored.
//  States:
//    IDLE -> REQ on fetch_req.
//    REQ  -> IDLE on mem_valid.
//    REQ  -> FAULT on wait_cnt==MAX_WAIT with no mem_valid.
//    FAULT is terminal: mem_req=0, busy=1, fetch_req ignored.
//  IDLE: mem_req=0. If pc_load and fetch_req are both 1 in the same cycle, pc<=pc_load_val first and the fetch uses the new PC.
//  REQ: mem_req=1 and mem_addr=pc, both held stable until mem_valid.
//    wait_cnt counts from 0 the cycle REQ is entered. mem_valid on the first REQ cycle is legal.
//  Completion (mem_valid in REQ), at the same edge:
//    ir<=mem_rdata; ir_valid=1 for exactly the next cycle.
//    pc<=pc+1 mod 2**PC_W (2**PC_W-1 wraps to 0), unless pend=1, in which case pc<=pend_val and pend<=0.
//  pc_load during REQ: does not disturb mem_addr. Captured into pend/pend_val (one deep; a later load overwrites pend_val).
//    Applied at completion in place of the increment.
//  mem_valid in IDLE or FAULT: ignored, no state change.
//  Latency: fetch_req at cycle N -> mem_req at N+1 -> mem_valid at N+1+k (0<=k<=MAX_WAIT) -> ir/ir_valid at N+2+k.
//  fetch_req while busy: ignored. The control unit must wait for ir_valid.
//  opcode and the control unit's decision state: the microprogram must not reach its decision state before ir_valid.
// TESTING
//  1. rst, then fetch_req, mem_valid one cycle later with rdata=16'h3A05 -> ir=16'h3A05, opcode=5'b00111, pc=1, ir_valid pulsed once.
//  2. pc_load_val=11'h7FF, fetch, mem_valid -> mem_addr=11'h7FF, pc wraps to 0.
//  3. fetch, then pc_load=11'h040 in the 2nd REQ cycle, mem_valid in the 4th -> mem_addr stays 0 throughout, pc=11'h040 after completion.
//  4. pc_load=11'h010 and fetch_req in the same IDLE cycle -> mem_addr=11'h010, pc=11'h011 after completion.
//  5. fetch with mem_valid never asserted -> fault=1 after 16 REQ cycles, mem_req=0; later fetch_req ignored; rst clears fault and pc=0.
//  6. rst asserted in REQ, then mem_valid the following cycle -> ir stays 0, ir_valid stays 0, state IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR instruction fetch stage with req/valid memory handshake and timeout watchdog
module fetch_unit #(
  parameter int PC_W     = 11,
  parameter int INSTR_W  = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               pc_load,
  input  logic [PC_W-1:0]    pc_load_val,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [4:0]         opcode,
  output logic               ir_valid,
  output logic               busy,
  output logic               fault
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, REQ, FAULT} state_t;
  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            pend;
  logic [PC_W-1:0] pend_val;
  logic            take;
  logic [PC_W-1:0] next_val;
  assign take     = pend | pc_load;
  assign next_val = pc_load ? pc_load_val : pend_val;
  assign mem_addr = pc;
  assign opcode   = ir[INSTR_W-1 -: 5];
  assign busy     = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      mem_req  <= 1'b0;
      ir_valid <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_load) pc <= pc_load_val;
          if (fetch_req) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (pc_load) begin
            pend     <= 1'b1;
            pend_val <= pc_load_val;
          end
          if (mem_valid) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
            pc       <= take ? next_val : pc + PC_W'(1);
            pend     <= 1'b0;
          end else if (wait_cnt == CW'(MAX_WAIT)) begin
            state   <= FAULT;
            mem_req <= 1'b0;
            fault   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with per-cycle reference model and literal spot checks for fetch_unit
module tb_fetch_unit;
  localparam int PC_W = 11;
  localparam int INSTR_W = 16;
  localparam int MAX_WAIT = 15;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fetch_req = 1'b0;
  logic               pc_load = 1'b0;
  logic [PC_W-1:0]    pc_load_val = '0;
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic [INSTR_W-1:0] mem_rdata = '0;
  logic               mem_valid = 1'b0;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [4:0]         opcode;
  logic               ir_valid;
  logic               busy;
  logic               fault;
  int n_chk = 0;
  int n_fail = 0;
  int m_phase = 0;
  int m_pc = 0;
  int m_ir = 0;
  int m_irv = 0;
  int m_fault = 0;
  int m_waited = 0;
  int m_pend = -1;
  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .pc(pc), .ir(ir),
    .opcode(opcode), .ir_valid(ir_valid), .busy(busy), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    chk("m_pc", int'(pc), m_pc);
    chk("m_ir", int'(ir), m_ir);
    chk("m_opcode", int'(opcode), m_ir / 2048);
    chk("m_ir_valid", int'(ir_valid), m_irv);
    chk("m_busy", int'(busy), int'(m_phase != 0));
    chk("m_fault", int'(fault), m_fault);
    chk("m_mem_req", int'(mem_req), int'(m_phase == 1));
    if (m_phase == 1) chk("m_mem_addr", int'(mem_addr), m_pc);
    m_irv = 0;
    if (rst) begin
      m_phase = 0; m_pc = 0; m_ir = 0; m_fault = 0; m_waited = 0; m_pend = -1;
    end else if (m_phase == 0) begin
      if (pc_load) m_pc = int'(pc_load_val);
      if (fetch_req) begin m_phase = 1; m_waited = 0; end
    end else if (m_phase == 1) begin
      if (pc_load) m_pend = int'(pc_load_val);
      if (mem_valid) begin
        m_ir = int'(mem_rdata);
        m_irv = 1;
        m_pc = (m_pend >= 0) ? m_pend : (m_pc + 1) % (1 << PC_W);
        m_pend = -1;
        m_phase = 0;
      end else if (m_waited == MAX_WAIT) begin
        m_phase = 2; m_fault = 1;
      end else m_waited++;
    end
  end
  initial begin
    step(2);
    rst = 1'b0;
    chk("reset_pc", int'(pc), 0);
    chk("reset_ir", int'(ir), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fault", int'(fault), 0);
    fetch_req = 1'b1; step();
    fetch_req = 1'b0;
    chk("t1_mem_req", int'(mem_req), 1);
    chk("t1_mem_addr", int'(mem_addr), 0);
    mem_valid = 1'b1; mem_rdata = 16'h3A05; step();
    mem_valid = 1'b0;
    chk("t1_ir_valid", int'(ir_valid), 1);
    chk("t1_ir", int'(ir), 16'h3A05);
    chk("t1_opcode", int'(opcode), 5'b00111);
    chk("t1_pc", int'(pc), 1);
    step();
    chk("t1_ir_valid_drop", int'(ir_valid), 0);
    pc_load = 1'b1; pc_load_val = 11'h7FF; step();
    pc_load = 1'b0; fetch_req = 1'b1; step();
    fetch_req = 1'b0;
    chk("t2_mem_addr", int'(mem_addr), 11'h7FF);
    mem_valid = 1'b1; mem_rdata = 16'hABCD; step();
    mem_valid = 1'b0;
    chk("t2_pc_wrap", int'(pc), 0);
    chk("t2_ir", int'(ir), 16'hABCD);
    fetch_req = 1'b1; step();
    fetch_req = 1'b0; step();
    pc_load = 1'b1; pc_load_val = 11'h040; step();
    pc_load = 1'b0;
    chk("t3_mem_addr_held", int'(mem_addr), 0);
    step();
    chk("t3_mem_addr_c4", int'(mem_addr), 0);
    mem_valid = 1'b1; mem_rdata = 16'h1234; step();
    mem_valid = 1'b0;
    chk("t3_pc_pend", int'(pc), 11'h040);
    pc_load = 1'b1; pc_load_val = 11'h010; fetch_req = 1'b1; step();
    pc_load = 1'b0; fetch_req = 1'b0;
    chk("t4_mem_addr", int'(mem_addr), 11'h010);
    mem_valid = 1'b1; mem_rdata = 16'hF800; step();
    mem_valid = 1'b0;
    chk("t4_pc", int'(pc), 11'h011);
    chk("t4_opcode", int'(opcode), 5'h1F);
    fetch_req = 1'b1; step();
    fetch_req = 1'b0; step(15);
    chk("t5_fault_early", int'(fault), 0);
    chk("t5_req_early", int'(mem_req), 1);
    step();
    chk("t5_fault", int'(fault), 1);
    chk("t5_mem_req", int'(mem_req), 0);
    chk("t5_busy", int'(busy), 1);
    fetch_req = 1'b1; mem_valid = 1'b1; step();
    fetch_req = 1'b0; mem_valid = 1'b0; step();
    chk("t5_fault_sticky", int'(fault), 1);
    chk("t5_req_ignored", int'(mem_req), 0);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("t5_fault_clr", int'(fault), 0);
    chk("t5_pc_clr", int'(pc), 0);
    fetch_req = 1'b1; step();
    fetch_req = 1'b0; rst = 1'b1; step();
    rst = 1'b0; mem_valid = 1'b1; mem_rdata = 16'hFFFF; step();
    mem_valid = 1'b0;
    chk("t6_ir", int'(ir), 0);
    chk("t6_ir_valid", int'(ir_valid), 0);
    chk("t6_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; step();
      fetch_req = 1'b0; step(i * 3);
      mem_valid = 1'b1; mem_rdata = 16'(16'h1111 * (i + 1)); step();
      mem_valid = 1'b0; step();
    end
    chk("loop_pc", int'(pc), 4);
    chk("loop_ir", int'(ir), 16'h4444);
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
